mem_bus_arb: RTL and testbench
==============================

// Module: mem_bus_arb
// PURPOSE
//  Arbitrates I-cache reads, D-cache reads and D-cache writes onto the single mem-bus port of the AXI bridge stage.
//  Keeps at most one read outstanding and returns re_data/re_valid to the master that owns it.
//  Holds reads while a write is still draining downstream, which preserves read-after-write order.
// PARAMETERS
//  ADDR_W   32    mem-bus address width
//  DATA_W   128   mem-bus data width
//  TYPE_W   4     r_type/iw_type width; encodes bytes-1 (0,1,3,7,15)
//  STRB_W   16    write strobe width
//  TMO_CYC  1024  read-timeout limit in cycles; must be at least 2
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       synchronous, active-low reset
//  i_r_req      in   1       I-side read request
//  i_r_type     in   TYPE_W  I-side read size
//  i_r_addr     in   ADDR_W  I-side read address
//  i_r_rdy      out  1       I-side request accepted this cycle
//  i_re_data    out  DATA_W  I-side read data
//  i_re_valid   out  1       I-side read data valid, 1-cycle pulse
//  d_r_req/d_r_type/d_r_addr/d_r_rdy/d_re_data/d_re_valid   D-side read port, same meanings as I side
//  d_iw_req     in   1       D-side write request
//  d_iw_type    in   TYPE_W  D-side write size
//  d_iw_addr    in   ADDR_W  D-side write address
//  d_iw_strb    in   STRB_W  D-side write strobe
//  d_iw_data    in   DATA_W  D-side write data
//  d_iw_rdy     out  1       D-side write accepted this cycle
//  r_req/r_type/r_addr  out  read request to the bridge;  r_rdy  in  bridge read idle
//  re_data      in   DATA_W  read data from the bridge;  re_valid  in  read data valid
//  iw_req/iw_type/iw_addr/iw_strb/iw_data  out  write request to the bridge;  iw_rdy  in  bridge write idle
//  err_tmo      out  1       sticky flag: a read exceeded TMO_CYC
// BEHAVIOUR
//  Handshakes: a request is accepted in any cycle where req and rdy are both 1. Masters hold their request until it is accepted.
//  Read FSM states: RD_IDLE, RD_I, RD_D. Reset state is RD_IDLE.
//   RD_IDLE -> RD_I or RD_D on read acceptance. RD_x -> RD_IDLE in the cycle re_valid=1.
//  Read acceptance requires all of: state RD_IDLE, r_rdy=1, wr_pend=0, and no d_iw_req in the same cycle.
//  Read request path: the granted master's req/type/addr drive r_* combinationally, with 0-cycle added latency.
//   x_r_rdy = grant_x & all acceptance conditions.
//  Read return: in RD_x, re_data is routed to x_re_data and re_valid to x_re_valid combinationally. The other side sees valid=0.
//   re_valid in RD_IDLE is dropped.
//  Back-to-back reads: the earliest next acceptance is the cycle after re_valid.
//  Write path: writes take priority over reads in the same cycle. iw_* pass through combinationally from D.
//   d_iw_rdy = iw_rdy & (rd_state==RD_IDLE).
//   wr_pend is set on write acceptance and cleared when iw_rdy returns to 1 on a later cycle.
//  Tie-break when I and D read in the same cycle: D wins, unless MEM_ARB_RR_EN is defined.
//  Timeout: counter tmo_cnt clears in RD_IDLE and increments each cycle in RD_x.
//   When tmo_cnt reaches TMO_CYC-1 without re_valid, err_tmo sets (sticky until reset).
//   The FSM keeps waiting after a timeout; it does not abort the read.
//  Reset (including mid-transaction): FSM -> RD_IDLE, wr_pend=0, tmo_cnt=0, err_tmo=0, rr_last=I.
//   All req/rdy/valid outputs are 0 during reset. A pending downstream beat is dropped, and masters must reissue.
//  Unsupported type codes pass through unchanged; the bridge defines their handling.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin tie-break. Register rr_last records the last granted reader.
//   On a tie the other side wins; rr_last updates on each read acceptance.
//  MEM_ARB_RR_EN undefined: fixed priority, D over I. No rr_last register.
// STRUCTURE
//  mem_bus_pkg: width constants, type codes (MT_B=0, MT_H=1, MT_W=3, MT_D=7, MT_Q=15), rd_state_t enum.
//  One sub-module, mem_arb_pick: 2-way request picker with rr/fixed mode. The FSM, wr_pend and timeout stay in mem_bus_arb.
// TESTING
//  Single I read at addr 0x8000_0000, type 15; bridge returns re_valid after 5 cycles
//   -> i_re_valid pulse with that data; d_re_valid stays 0.
//  i_r_req and d_r_req asserted together, both held
//   -> without RR: D granted, then I.
//   -> with RR: D, I, D, I alternate over 4 reads.
//  d_iw_req and d_r_req together; iw_rdy drops for 3 cycles
//   -> write accepted first; read accepted only after iw_rdy returns to 1.
//  re_valid injected while FSM is RD_IDLE -> no x_re_valid output; state unchanged.
//  Bridge never returns data, TMO_CYC=16 -> err_tmo=1 after 16 cycles in RD_x; it stays 1 after a late re_valid.
//  rst_n=0 asserted while in RD_D -> next cycle: all rdy/valid outputs 0, err_tmo=0; a new I read is accepted after reset.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg
//   Shared constants for the mem-bus arbiter slice: default bus widths,
//   access-size type codes (bytes-1 encoding) and the read FSM state enum.
//   No ports; imported by mem_arb_pick and mem_bus_arb.
package mem_bus_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 128;
    localparam int TYPE_W_DEF  = 4;
    localparam int STRB_W_DEF  = 16;
    localparam int TMO_CYC_DEF = 1024;

    // Access size codes: value is the access length in bytes minus one.
    localparam logic [3:0] MT_B = 4'd0;
    localparam logic [3:0] MT_H = 4'd1;
    localparam logic [3:0] MT_W = 4'd3;
    localparam logic [3:0] MT_D = 4'd7;
    localparam logic [3:0] MT_Q = 4'd15;

    // Which master owns the single outstanding read, if any.
    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_I    = 2'd1,
        RD_D    = 2'd2
    } rd_state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick
//   Two-way read request picker (I side vs D side).
//   RR_EN = 0 : fixed priority, D wins a tie.
//   RR_EN = 1 : on a tie the side that was not granted last wins.
// Ports
//   i_req    in   I-side read request
//   d_req    in   D-side read request
//   last_i   in   1 when the most recent read grant went to the I side
//   grant_i  out  I side selected
//   grant_d  out  D side selected
module mem_arb_pick
    import mem_bus_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic i_req,
    input  logic d_req,
    input  logic last_i,
    output logic grant_i,
    output logic grant_d
);

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (i_req && d_req) begin
            // Tie: with round-robin, I only wins when D was served last.
            if (RR_EN && !last_i) begin
                grant_i = 1'b1;
            end else begin
                grant_d = 1'b1;
            end
        end else if (d_req) begin
            grant_d = 1'b1;
        end else if (i_req) begin
            grant_i = 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arb.sv
// mem_bus_arb
//   Arbitrates I-cache reads, D-cache reads and D-cache writes onto the single
//   mem-bus port of the AXI bridge stage. At most one read is outstanding; its
//   return data is routed to the master that issued it. Reads are held off while
//   a write is still draining downstream so read-after-write order is preserved.
//   A sticky err_tmo flags a read that has waited TMO_CYC cycles; the read is
//   not aborted.
//
// Build option
//   MEM_ARB_RR_EN : when defined, I/D read ties are broken round-robin
//                   (rr_last register); otherwise D has fixed priority.
//
// Ports
//   clk, rst_n                       clock, synchronous active-low reset
//   i_r_req/type/addr -> i_r_rdy     I-side read request / accepted this cycle
//   i_re_data, i_re_valid            I-side read return (1-cycle valid pulse)
//   d_r_req/type/addr -> d_r_rdy     D-side read request / accepted this cycle
//   d_re_data, d_re_valid            D-side read return
//   d_iw_req/type/addr/strb/data     D-side write request
//   d_iw_rdy                         D-side write accepted this cycle
//   r_req/type/addr, r_rdy           read request to bridge, bridge read idle
//   re_data, re_valid                read data from bridge
//   iw_req/type/addr/strb/data       write request to bridge
//   iw_rdy                           bridge write idle
//   err_tmo                          sticky read-timeout flag
module mem_bus_arb
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TYPE_W  = TYPE_W_DEF,
    parameter int STRB_W  = STRB_W_DEF,
    parameter int TMO_CYC = TMO_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_r_req,
    input  logic [TYPE_W-1:0] i_r_type,
    input  logic [ADDR_W-1:0] i_r_addr,
    output logic              i_r_rdy,
    output logic [DATA_W-1:0] i_re_data,
    output logic              i_re_valid,

    input  logic              d_r_req,
    input  logic [TYPE_W-1:0] d_r_type,
    input  logic [ADDR_W-1:0] d_r_addr,
    output logic              d_r_rdy,
    output logic [DATA_W-1:0] d_re_data,
    output logic              d_re_valid,

    input  logic              d_iw_req,
    input  logic [TYPE_W-1:0] d_iw_type,
    input  logic [ADDR_W-1:0] d_iw_addr,
    input  logic [STRB_W-1:0] d_iw_strb,
    input  logic [DATA_W-1:0] d_iw_data,
    output logic              d_iw_rdy,

    output logic              r_req,
    output logic [TYPE_W-1:0] r_type,
    output logic [ADDR_W-1:0] r_addr,
    input  logic              r_rdy,
    input  logic [DATA_W-1:0] re_data,
    input  logic              re_valid,

    output logic              iw_req,
    output logic [TYPE_W-1:0] iw_type,
    output logic [ADDR_W-1:0] iw_addr,
    output logic [STRB_W-1:0] iw_strb,
    output logic [DATA_W-1:0] iw_data,
    input  logic              iw_rdy,

    output logic              err_tmo
);

    localparam int               CNT_W    = $clog2(TMO_CYC);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

    rd_state_t        rd_state_q, rd_state_d;
    logic             wr_pend_q,  wr_pend_d;
    logic [CNT_W-1:0] tmo_cnt_q,  tmo_cnt_d;
    logic             err_tmo_q,  err_tmo_d;

    logic rd_idle;
    logic rd_open;
    logic grant_i;
    logic grant_d;
    logic rd_acc;
    logic wr_acc;
    logic last_i;

    assign rd_idle = (rd_state_q == RD_IDLE);

    // A read may be presented to the bridge only when nothing is outstanding,
    // no write is draining and no write is competing this cycle. rst_n is
    // folded in so every handshake output is quiet while reset is held.
    assign rd_open = rst_n & rd_idle & ~wr_pend_q & ~d_iw_req;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;

    logic rr_last_i_q, rr_last_i_d;

    always_comb begin
        rr_last_i_d = rr_last_i_q;
        if (rd_acc) begin
            rr_last_i_d = i_r_rdy;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_last_i_q <= 1'b1;
        end else begin
            rr_last_i_q <= rr_last_i_d;
        end
    end

    assign last_i = rr_last_i_q;
`else
    localparam bit RR_EN = 1'b0;

    // Fixed priority ignores history; tie to the "I served last" value.
    assign last_i = 1'b1;
`endif

    mem_arb_pick #(
        .RR_EN (RR_EN)
    ) u_pick (
        .i_req   (i_r_req),
        .d_req   (d_r_req),
        .last_i  (last_i),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    // Request / return routing
    always_comb begin
        r_req   = rd_open & (grant_i | grant_d);
        r_type  = grant_d ? d_r_type : i_r_type;
        r_addr  = grant_d ? d_r_addr : i_r_addr;
        i_r_rdy = rd_open & grant_i & r_rdy;
        d_r_rdy = rd_open & grant_d & r_rdy;
        rd_acc  = i_r_rdy | d_r_rdy;

        // Writes are only offered while no read is outstanding so the bridge
        // never takes a write that the D side has not seen accepted.
        iw_req   = rst_n & rd_idle & d_iw_req;
        iw_type  = d_iw_type;
        iw_addr  = d_iw_addr;
        iw_strb  = d_iw_strb;
        iw_data  = d_iw_data;
        d_iw_rdy = rst_n & rd_idle & iw_rdy;
        wr_acc   = d_iw_req & d_iw_rdy;

        i_re_valid = rst_n & (rd_state_q == RD_I) & re_valid;
        d_re_valid = rst_n & (rd_state_q == RD_D) & re_valid;
        i_re_data  = (rd_state_q == RD_I) ? re_data : '0;
        d_re_data  = (rd_state_q == RD_D) ? re_data : '0;

        err_tmo = err_tmo_q;
    end

    // Next-state: read FSM, write drain tracking, timeout
    always_comb begin
        rd_state_d = rd_state_q;
        wr_pend_d  = wr_pend_q;
        tmo_cnt_d  = tmo_cnt_q;
        err_tmo_d  = err_tmo_q;

        case (rd_state_q)
            RD_IDLE: begin
                if (i_r_rdy) begin
                    rd_state_d = RD_I;
                end else if (d_r_rdy) begin
                    rd_state_d = RD_D;
                end
            end
            RD_I, RD_D: begin
                if (re_valid) begin
                    rd_state_d = RD_IDLE;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase

        // iw_rdy returning high on a later cycle means the bridge has finished
        // the write it took; a fresh acceptance re-arms the hold.
        if (wr_acc) begin
            wr_pend_d = 1'b1;
        end else if (iw_rdy) begin
            wr_pend_d = 1'b0;
        end

        // Counter saturates at TMO_LAST so a long stall cannot wrap it.
        if (rd_idle || re_valid) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_LAST) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end

        if (!rd_idle && !re_valid && (tmo_cnt_q == TMO_LAST)) begin
            err_tmo_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            wr_pend_q  <= 1'b0;
            tmo_cnt_q  <= '0;
            err_tmo_q  <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_pend_q  <= wr_pend_d;
            tmo_cnt_q  <= tmo_cnt_d;
            err_tmo_q  <= err_tmo_d;
        end
    end

endmodule

// File: tb/tb_mem_bus_arb.sv
// tb_mem_bus_arb
//   Self-checking bench for mem_bus_arb: a table of single-cycle vectors from
//   idle, hand-written multi-cycle sequences, then randomized traffic compared
//   against a transaction-level reference model. TMO_CYC is set to 16.
module tb_mem_bus_arb;
    import mem_bus_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int TYPE_W = 4;
    localparam int STRB_W = 16;
    localparam int TMO    = 16;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_r_req, d_r_req, d_iw_req;
    logic [TYPE_W-1:0] i_r_type, d_r_type, d_iw_type;
    logic [ADDR_W-1:0] i_r_addr, d_r_addr, d_iw_addr;
    logic [STRB_W-1:0] d_iw_strb;
    logic [DATA_W-1:0] d_iw_data;
    logic              i_r_rdy, d_r_rdy, d_iw_rdy;
    logic [DATA_W-1:0] i_re_data, d_re_data;
    logic              i_re_valid, d_re_valid;
    logic              r_req, r_rdy, re_valid, iw_req, iw_rdy, err_tmo;
    logic [TYPE_W-1:0] r_type, iw_type;
    logic [ADDR_W-1:0] r_addr, iw_addr;
    logic [STRB_W-1:0] iw_strb;
    logic [DATA_W-1:0] re_data, iw_data;

    mem_bus_arb #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .TYPE_W (TYPE_W),
        .STRB_W (STRB_W), .TMO_CYC (TMO)
    ) dut (
        .clk        (clk),        .rst_n      (rst_n),
        .i_r_req    (i_r_req),    .i_r_type   (i_r_type),   .i_r_addr  (i_r_addr),
        .i_r_rdy    (i_r_rdy),    .i_re_data  (i_re_data),  .i_re_valid(i_re_valid),
        .d_r_req    (d_r_req),    .d_r_type   (d_r_type),   .d_r_addr  (d_r_addr),
        .d_r_rdy    (d_r_rdy),    .d_re_data  (d_re_data),  .d_re_valid(d_re_valid),
        .d_iw_req   (d_iw_req),   .d_iw_type  (d_iw_type),  .d_iw_addr (d_iw_addr),
        .d_iw_strb  (d_iw_strb),  .d_iw_data  (d_iw_data),  .d_iw_rdy  (d_iw_rdy),
        .r_req      (r_req),      .r_type     (r_type),     .r_addr    (r_addr),
        .r_rdy      (r_rdy),      .re_data    (re_data),    .re_valid  (re_valid),
        .iw_req     (iw_req),     .iw_type    (iw_type),    .iw_addr   (iw_addr),
        .iw_strb    (iw_strb),    .iw_data    (iw_data),    .iw_rdy    (iw_rdy),
        .err_tmo    (err_tmo)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // {r_req, i_r_rdy, d_r_rdy, iw_req, d_iw_rdy, i_re_valid, d_re_valid}
    function automatic logic [6:0] ctl7();
        return {r_req, i_r_rdy, d_r_rdy, iw_req, d_iw_rdy, i_re_valid, d_re_valid};
    endfunction

    task automatic clear_inputs();
        i_r_req = 0; d_r_req = 0; d_iw_req = 0;
        i_r_type = MT_Q; d_r_type = MT_W; d_iw_type = MT_D;
        i_r_addr = 32'h8000_0000; d_r_addr = 32'h1000_0040; d_iw_addr = 32'h2000_0080;
        d_iw_strb = 16'h00ff; d_iw_data = {4{32'hc0de_0001}};
        r_rdy = 0; iw_rdy = 0; re_valid = 0; re_data = '0;
    endtask

    // Leaves the caller at a negedge with rst_n released and the DUT idle.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    typedef struct {
        logic       i_req, d_req, w_req, rrdy, iwrdy, rv;
        logic [6:0] exp;
        logic       src_d;
    } vec_t;

    function automatic vec_t mk(logic i_req, logic d_req, logic w_req, logic rrdy,
                                logic iwrdy, logic rv, logic [6:0] exp, logic src_d);
        vec_t v;
        v.i_req = i_req; v.d_req = d_req; v.w_req = w_req; v.rrdy = rrdy;
        v.iwrdy = iwrdy; v.rv = rv; v.exp = exp; v.src_d = src_d;
        return v;
    endfunction

    // Reference model state (transaction level)
    int out_q[$];      // owner of the outstanding read: 1 = I, 2 = D
    bit draining;
    int waited;
    bit err_m;
    int last_rd;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[9];
        int   exp_b[4];
        int   nreads;
        int   got;
        logic [DATA_W-1:0] pat;

        rst_n = 0;
        clear_inputs();

        // ---------------- table vectors, each from a fresh idle state ----------------
        vt[0] = mk(0, 0, 0, 0, 0, 0, 7'b0000000, 0);
        vt[1] = mk(1, 0, 0, 1, 1, 0, 7'b1100100, 0);
        vt[2] = mk(0, 1, 0, 1, 0, 0, 7'b1010000, 1);
        vt[3] = mk(1, 1, 0, 1, 0, 0, 7'b1010000, 1);
        vt[4] = mk(1, 1, 0, 0, 1, 0, 7'b1000100, 1);
        vt[5] = mk(0, 1, 1, 1, 1, 0, 7'b0001100, 0);
        vt[6] = mk(1, 0, 1, 1, 0, 0, 7'b0001000, 0);
        vt[7] = mk(0, 0, 0, 0, 0, 1, 7'b0000000, 0);
        vt[8] = mk(1, 0, 0, 0, 0, 0, 7'b1000000, 0);

        for (int v = 0; v < 9; v++) begin
            do_reset();
            i_r_req = vt[v].i_req; d_r_req = vt[v].d_req; d_iw_req = vt[v].w_req;
            r_rdy = vt[v].rrdy; iw_rdy = vt[v].iwrdy; re_valid = vt[v].rv;
            #1;
            chk($sformatf("vec%0d_ctl", v), ctl7(), vt[v].exp);
            if (vt[v].exp[6]) begin
                chk($sformatf("vec%0d_addr", v), r_addr,
                    vt[v].src_d ? 32'h1000_0040 : 32'h8000_0000);
            end
        end

        // ---------------- A: single I read, data after 5 cycles ----------------
        do_reset();
        i_r_req = 1; i_r_type = MT_Q; i_r_addr = 32'h8000_0000; r_rdy = 1;
        #1;
        chk("A_i_rdy", i_r_rdy, 1);
        chk("A_r_addr", r_addr, 32'h8000_0000);
        chk("A_r_type", r_type, MT_Q);
        @(negedge clk);
        i_r_req = 0; r_rdy = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("A_wait", {i_re_valid, d_re_valid, r_req}, 0);
            @(negedge clk);
        end
        pat = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
        re_valid = 1; re_data = pat;
        #1;
        chk("A_i_valid", i_re_valid, 1);
        chk("A_i_data", i_re_data, pat);
        chk("A_d_valid", d_re_valid, 0);
        @(negedge clk);
        re_valid = 0;
        #1;
        chk("A_pulse_end", i_re_valid, 0);

        // ---------------- B: simultaneous I and D reads ----------------
        do_reset();
        i_r_req = 1; d_r_req = 1; r_rdy = 1;
        exp_b = '{2, 1, 2, 1};
        nreads = RR ? 4 : 2;
        for (int r = 0; r < nreads; r++) begin
            got = -1;
            for (int t = 0; t < 8; t++) begin
                #1;
                if (i_r_rdy || d_r_rdy) begin
                    got = d_r_rdy ? 2 : 1;
                    break;
                end
                @(negedge clk);
            end
            chk($sformatf("B_grant%0d", r), got, exp_b[r]);
            @(negedge clk);
            if (!RR) begin
                if (got == 2) d_r_req = 0;
                else          i_r_req = 0;
            end
            re_valid = 1; re_data = {4{32'(r)}};
            #1;
            chk($sformatf("B_ret%0d", r), {i_re_valid, d_re_valid},
                (exp_b[r] == 2) ? 2'b01 : 2'b10);
            @(negedge clk);
            re_valid = 0;
        end
        i_r_req = 0; d_r_req = 0;

        // ---------------- C: write first, read waits for drain ----------------
        do_reset();
        d_iw_req = 1; d_r_req = 1; iw_rdy = 1; r_rdy = 1;
        #1;
        chk("C_wr_first", {iw_req, d_iw_rdy, d_r_rdy, r_req}, 4'b1100);
        @(negedge clk);
        d_iw_req = 0; iw_rdy = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("C_rd_held", {d_r_rdy, r_req}, 2'b00);
            @(negedge clk);
        end
        iw_rdy = 1;
        #1;
        chk("C_drain_cycle", d_r_rdy, 0);
        @(negedge clk);
        #1;
        chk("C_rd_after", d_r_rdy, 1);
        @(negedge clk);
        d_r_req = 0; re_valid = 1;
        #1;
        chk("C_d_valid", d_re_valid, 1);
        @(negedge clk);
        re_valid = 0;

        // ---------------- D: stray re_valid while idle ----------------
        do_reset();
        re_valid = 1; re_data = {4{32'hdead_beef}};
        #1;
        chk("D_no_valid", {i_re_valid, d_re_valid}, 2'b00);
        @(negedge clk);
        re_valid = 0; i_r_req = 1; r_rdy = 1;
        #1;
        chk("D_still_idle", i_r_rdy, 1);
        @(negedge clk);
        i_r_req = 0; re_valid = 1;
        #1;
        chk("D_i_valid", i_re_valid, 1);
        @(negedge clk);
        re_valid = 0;

        // ---------------- E: read timeout, flag is sticky ----------------
        do_reset();
        i_r_req = 1; r_rdy = 1;
        #1;
        chk("E_acc", i_r_rdy, 1);
        @(negedge clk);
        i_r_req = 0; r_rdy = 0;
        for (int k = 1; k <= TMO; k++) begin
            #1;
            chk($sformatf("E_no_err_c%0d", k), err_tmo, 0);
            @(negedge clk);
        end
        #1;
        chk("E_err_set", err_tmo, 1);
        @(negedge clk);
        re_valid = 1;
        #1;
        chk("E_late_valid", i_re_valid, 1);
        @(negedge clk);
        re_valid = 0;
        #1;
        chk("E_err_sticky", err_tmo, 1);

        // ---------------- F: reset while a D read is outstanding ----------------
        d_r_req = 1; r_rdy = 1;
        #1;
        chk("F_d_acc", d_r_rdy, 1);
        @(negedge clk);
        rst_n = 0;
        i_r_req = 1; d_r_req = 1; d_iw_req = 1; r_rdy = 1; iw_rdy = 1; re_valid = 1;
        #1;
        chk("F_in_reset", ctl7(), 7'b0);
        @(negedge clk);
        rst_n = 1;
        clear_inputs();
        #1;
        chk("F_after_ctl", ctl7(), 7'b0);
        chk("F_after_err", err_tmo, 0);
        @(negedge clk);
        i_r_req = 1; r_rdy = 1;
        #1;
        chk("F_new_i_read", {i_r_rdy, d_r_rdy}, 2'b10);
        @(negedge clk);
        i_r_req = 0; re_valid = 1;
        #1;
        chk("F_i_valid", i_re_valid, 1);
        @(negedge clk);
        re_valid = 0;

        // ---------------- random traffic vs reference model ----------------
        do_reset();
        out_q.delete(); draining = 0; waited = 0; err_m = 0; last_rd = 1;
        begin
            bit acc_i, acc_d, acc_w;
            acc_i = 0; acc_d = 0; acc_w = 0;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                bit busy, open, e_ir, e_dr, e_rq, e_iwq, e_diw, e_iv, e_dv;
                int win;
                if (cyc != 0) @(negedge clk);
                rst_n = ($urandom_range(0, 99) != 0);
                if (!rst_n) begin
                    i_r_req = 0; d_r_req = 0; d_iw_req = 0;
                end else begin
                    if (acc_i) i_r_req = 0;
                    else if (!i_r_req && $urandom_range(0, 99) < 35) begin
                        i_r_req = 1; i_r_addr = $urandom; i_r_type = TYPE_W'($urandom_range(0, 15));
                    end
                    if (acc_d) d_r_req = 0;
                    else if (!d_r_req && $urandom_range(0, 99) < 35) begin
                        d_r_req = 1; d_r_addr = $urandom; d_r_type = TYPE_W'($urandom_range(0, 15));
                    end
                    if (acc_w) d_iw_req = 0;
                    else if (!d_iw_req && $urandom_range(0, 99) < 20) begin
                        d_iw_req = 1; d_iw_addr = $urandom; d_iw_data = {4{$urandom}};
                        d_iw_strb = STRB_W'($urandom);
                    end
                end
                r_rdy    = ($urandom_range(0, 99) < 70);
                iw_rdy   = ($urandom_range(0, 99) < 60);
                re_valid = ($urandom_range(0, 99) < 25);
                re_data  = {$urandom, $urandom, $urandom, $urandom};
                #1;

                busy = (out_q.size() != 0);
                open = rst_n && !busy && !draining && !d_iw_req;
                if (i_r_req && d_r_req) win = RR ? ((last_rd == 1) ? 2 : 1) : 2;
                else if (d_r_req)       win = 2;
                else if (i_r_req)       win = 1;
                else                    win = 0;
                e_rq  = open && (win != 0);
                e_ir  = open && (win == 1) && r_rdy;
                e_dr  = open && (win == 2) && r_rdy;
                e_iwq = rst_n && !busy && d_iw_req;
                e_diw = rst_n && !busy && iw_rdy;
                e_iv  = rst_n && busy && (out_q[0] == 1) && re_valid;
                e_dv  = rst_n && busy && (out_q[0] == 2) && re_valid;

                chk("RND_ctl", {ctl7(), err_tmo},
                    {e_rq, e_ir, e_dr, e_iwq, e_diw, e_iv, e_dv, err_m});
                if (e_rq) chk("RND_r_addr", r_addr, (win == 2) ? d_r_addr : i_r_addr);
                if (e_iv) chk("RND_i_data", i_re_data, re_data);
                if (e_dv) chk("RND_d_data", d_re_data, re_data);
                if (e_iwq) chk("RND_iw", {iw_addr, iw_strb, iw_data[31:0]},
                               {d_iw_addr, d_iw_strb, d_iw_data[31:0]});

                acc_i = e_ir; acc_d = e_dr; acc_w = d_iw_req && e_diw;
                if (!rst_n) begin
                    out_q.delete(); draining = 0; waited = 0; err_m = 0; last_rd = 1;
                    acc_i = 0; acc_d = 0; acc_w = 0;
                end else begin
                    if (busy) begin
                        if (re_valid) void'(out_q.pop_front());
                        else begin
                            waited++;
                            if (waited >= TMO) err_m = 1;
                        end
                    end else if (e_ir || e_dr) begin
                        out_q.push_back(win); waited = 0; last_rd = win;
                    end
                    if (acc_w)       draining = 1;
                    else if (iw_rdy) draining = 0;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
